// File: rtl/relu_readout.sv
// relu_readout: layer-1 read-out stage behind the per-node accumulator bank.
// On a load strobe the whole accumulator bank is snapshotted and a one-cycle
// clear is sent back to the bank. The snapshot then streams out one node per
// valid/ready handshake. Each value goes through ReLU, a logical right-shift
// requantisation and unsigned saturation on the way out.
module relu_readout #(
    parameter int NODES = 16,
    parameter int IN_W  = 16,
    parameter int OUT_W = 8,
    parameter int SHIFT = 4
) (
    input  logic                       clk,
    input  logic                       clr_n,
    input  logic [NODES*IN_W-1:0]      sum_in,
    input  logic                       load,
    output logic                       acc_clr,
    output logic [OUT_W-1:0]           out_data,
    output logic [$clog2(NODES)-1:0]   out_index,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic                       busy,
    output logic                       overrun
);

    localparam int IDX_W = $clog2(NODES);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NODES - 1);
    localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(0);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    // ReLU, then logical right shift, then clamp to the unsigned output range.
    function automatic logic [OUT_W-1:0] requant(input logic [IN_W-1:0] sum);
        logic [IN_W-1:0] r;
        logic [IN_W-1:0] q;
        if (sum[IN_W-1]) begin
            r = {IN_W{1'b0}};
        end else begin
            r = sum;
        end
        q = r >> SHIFT;
        if ((q >> OUT_W) != {IN_W{1'b0}}) begin
            requant = {OUT_W{1'b1}};
        end else begin
            requant = q[OUT_W-1:0];
        end
    endfunction

    state_t                  state_r;
    logic [IDX_W-1:0]        idx_r;
    logic [IN_W-1:0]         snap_r [NODES];
    logic                    acc_clr_r;
    logic [OUT_W-1:0]        out_data_r;
    logic                    out_valid_r;
    logic                    out_last_r;
    logic                    busy_r;
    logic                    overrun_r;

    logic                    capture_s;
    logic                    transfer_s;
    logic [IDX_W-1:0]        next_idx_s;
    logic [OUT_W-1:0]        next_data_s;
    logic [OUT_W-1:0]        first_data_s;

    // Handshake decode and the requantised value of the node that comes next.
    always_comb begin
        capture_s    = 1'b0;
        transfer_s   = 1'b0;
        next_idx_s   = idx_r + IDX_W'(1);
        next_data_s  = {OUT_W{1'b0}};
        first_data_s = requant(sum_in[IN_W-1:0]);
        if (state_r == ST_IDLE) begin
            capture_s = load;
        end else begin
            capture_s = 1'b0;
        end
        if (out_valid_r && out_ready) begin
            transfer_s = 1'b1;
        end else begin
            transfer_s = 1'b0;
        end
        if (idx_r != LAST_IDX) begin
            next_data_s = requant(snap_r[next_idx_s]);
        end else begin
            next_data_s = {OUT_W{1'b0}};
        end
    end

    // Snapshot bank: captured on the load edge, so the bank clear that follows
    // cannot reach the held data.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int m = 0; m < NODES; m++) begin
                snap_r[m] <= {IN_W{1'b0}};
            end
        end else if (capture_s) begin
            for (int m = 0; m < NODES; m++) begin
                snap_r[m] <= sum_in[m*IN_W +: IN_W];
            end
        end
    end

    // Frame FSM with all stream outputs registered; the beat for the next
    // index is precomputed so out_data always matches out_index.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_r     <= ST_IDLE;
            idx_r       <= FIRST_IDX;
            acc_clr_r   <= 1'b0;
            out_data_r  <= {OUT_W{1'b0}};
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    acc_clr_r <= load;
                    if (load) begin
                        state_r     <= ST_STREAM;
                        idx_r       <= FIRST_IDX;
                        out_valid_r <= 1'b1;
                        out_data_r  <= first_data_s;
                        out_last_r  <= (LAST_IDX == FIRST_IDX);
                        busy_r      <= 1'b1;
                    end
                end
                ST_STREAM: begin
                    acc_clr_r <= 1'b0;
                    if (load) begin
                        overrun_r <= 1'b1;
                    end
                    if (transfer_s) begin
                        if (idx_r == LAST_IDX) begin
                            state_r     <= ST_IDLE;
                            out_valid_r <= 1'b0;
                            out_last_r  <= 1'b0;
                            out_data_r  <= {OUT_W{1'b0}};
                            busy_r      <= 1'b0;
                        end else begin
                            idx_r      <= next_idx_s;
                            out_data_r <= next_data_s;
                            out_last_r <= (next_idx_s == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    idx_r       <= FIRST_IDX;
                    acc_clr_r   <= 1'b0;
                    out_data_r  <= {OUT_W{1'b0}};
                    out_valid_r <= 1'b0;
                    out_last_r  <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign acc_clr   = acc_clr_r;
    assign out_data  = out_data_r;
    assign out_index = idx_r;
    assign out_valid = out_valid_r;
    assign out_last  = out_last_r;
    assign busy      = busy_r;
    assign overrun   = overrun_r;

endmodule

// File: tb/tb_relu_readout.sv
// Scoreboard bench for relu_readout: each frame load pushes its hand-computed
// beats into a queue; a negedge monitor compares every presented beat with
// the queue head and pops it when the handshake completes.
module tb_relu_readout;

    localparam int NODES = 16;
    localparam int IN_W  = 16;
    localparam int OUT_W = 8;

    logic                    clk;
    logic                    clr_n;
    logic [NODES*IN_W-1:0]   sum_in;
    logic                    load;
    logic                    acc_clr;
    logic [OUT_W-1:0]        out_data;
    logic [3:0]              out_index;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_last;
    logic                    busy;
    logic                    overrun;

    typedef struct {
        int idx;
        int data;
        int last;
    } beat_t;

    beat_t exp_q [$];
    int    tests_run = 0;
    int    tests_failed = 0;
    logic  toggle_mode = 1'b0;

    relu_readout #(.NODES(NODES), .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(4)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .sum_in    (sum_in),
        .load      (load),
        .acc_clr   (acc_clr),
        .out_data  (out_data),
        .out_index (out_index),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive sum_in/load and queue the hand-computed beats of that frame.
    task automatic start_frame(input logic [NODES*IN_W-1:0] s,
                               input logic [NODES*OUT_W-1:0] e);
        beat_t b;
        sum_in = s;
        load   = 1'b1;
        for (int k = 0; k < NODES; k++) begin
            b.idx  = k;
            b.data = int'(e[k*OUT_W +: OUT_W]);
            b.last = (k == NODES - 1) ? 1 : 0;
            exp_q.push_back(b);
        end
    endtask

    task automatic wait_drain(input string name);
        int left;
        left = 400;
        while ((exp_q.size() != 0 || out_valid) && left > 0) begin
            tick();
            left--;
        end
        check({name, " drained"}, exp_q.size(), 0);
        check({name, " valid low"}, int'(out_valid), 0);
    endtask

    // Ready driver: held high, or the 1,0,0,1 pattern when toggling.
    initial begin
        int cnt;
        int pat [4];
        pat = '{1, 0, 0, 1};
        cnt = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (toggle_mode) begin
                out_ready = pat[cnt % 4] != 0;
                cnt++;
            end else begin
                out_ready = 1'b1;
                cnt = 0;
            end
        end
    end

    // Monitor: every presented beat must equal the queue head, stall or not.
    always @(negedge clk) begin
        if (clr_n) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected beat index", int'(out_index), -1);
                end else begin
                    check("beat index", int'(out_index), exp_q[0].idx);
                    check("beat data", int'(out_data), exp_q[0].data);
                    check("beat last", int'(out_last), exp_q[0].last);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                    end
                end
            end else begin
                check("last while idle", int'(out_last), 0);
            end
        end
    end

    initial begin
        logic [NODES*IN_W-1:0]  s_a, s_sat, s_new, s_b2;
        logic [NODES*OUT_W-1:0] e_a, e_sat, e_new, e_b2;

        // Frame A
        s_a = {NODES{16'h0010}};
        s_a[15:0] = 16'h0123; s_a[31:16] = 16'hFF00; s_a[47:32] = 16'h7FFF;
        e_a = {NODES{8'h01}};
        e_a[7:0] = 8'h12; e_a[15:8] = 8'h00; e_a[23:16] = 8'hFF;
        // Saturation corners
        s_sat = {NODES{16'hFFFF}};
        s_sat[15:0] = 16'h0FF0; s_sat[31:16] = 16'h1000;
        s_sat[47:32] = 16'h0FEF; s_sat[63:48] = 16'h8000;
        s_sat[79:64] = 16'h000F; s_sat[95:80] = 16'h07FF;
        e_sat = {NODES{8'h00}};
        e_sat[7:0] = 8'hFF; e_sat[15:8] = 8'hFF; e_sat[23:16] = 8'hFE;
        e_sat[31:24] = 8'h00; e_sat[39:32] = 8'h00; e_sat[47:40] = 8'h7F;
        // Frame after mid-stream reset
        s_new = {NODES{16'h0250}};
        s_new[15:0] = 16'h0AB0;
        e_new = {NODES{8'h25}};
        e_new[7:0] = 8'hAB;
        // Second back-to-back frame
        s_b2 = {NODES{16'h0340}};
        s_b2[255:240] = 16'hF000;
        e_b2 = {NODES{8'h34}};
        e_b2[127:120] = 8'h00;

        clr_n = 1'b0;
        load = 1'b0;
        sum_in = '0;
        #12;
        check("reset valid", int'(out_valid), 0);
        check("reset data", int'(out_data), 0);
        check("reset index", int'(out_index), 0);
        check("reset last", int'(out_last), 0);
        check("reset acc_clr", int'(acc_clr), 0);
        check("reset busy", int'(busy), 0);
        check("reset overrun", int'(overrun), 0);
        tick();
        clr_n = 1'b1;
        tick();
        tick();

        // Basic frame, ready held high
        start_frame(s_a, e_a);
        tick();
        load = 1'b0;
        check("A acc_clr pulse", int'(acc_clr), 1);
        check("A first valid", int'(out_valid), 1);
        check("A busy", int'(busy), 1);
        tick();
        check("A acc_clr one cycle", int'(acc_clr), 0);
        wait_drain("A");
        check("A idle busy", int'(busy), 0);

        // Same frame with ready toggling 1,0,0,1
        toggle_mode = 1'b1;
        tick();
        start_frame(s_a, e_a);
        tick();
        load = 1'b0;
        wait_drain("toggle");
        toggle_mode = 1'b0;
        tick();
        tick();

        // Requantisation corners
        start_frame(s_sat, e_sat);
        tick();
        load = 1'b0;
        wait_drain("sat");
        tick();

        // Reset at index 7
        start_frame(s_a, e_a);
        tick();
        load = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("pre-reset index", int'(out_index), 7);
        clr_n = 1'b0;
        #1;
        exp_q.delete();
        check("mid reset valid", int'(out_valid), 0);
        check("mid reset data", int'(out_data), 0);
        check("mid reset index", int'(out_index), 0);
        check("mid reset busy", int'(busy), 0);
        check("mid reset last", int'(out_last), 0);
        tick();
        clr_n = 1'b1;
        tick();
        start_frame(s_new, e_new);
        tick();
        load = 1'b0;
        check("new acc_clr", int'(acc_clr), 1);
        wait_drain("after reset");
        tick();

        // Back-to-back: second load in the first IDLE cycle
        start_frame(s_a, e_a);
        tick();
        load = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        check("b2b idle", int'(busy), 0);
        start_frame(s_b2, e_b2);
        tick();
        load = 1'b0;
        sum_in = '0;
        check("b2b acc_clr", int'(acc_clr), 1);
        check("b2b valid", int'(out_valid), 1);
        wait_drain("b2b");
        check("b2b no overrun", int'(overrun), 0);
        tick();

        // Overrun: load at beat 5 and with the final transfer
        start_frame(s_a, e_a);
        tick();
        load = 1'b0;
        sum_in = s_sat;
        for (int i = 0; i < 5; i++) tick();
        load = 1'b1;
        tick();
        load = 1'b0;
        check("ovr acc_clr mid", int'(acc_clr), 0);
        check("ovr set", int'(overrun), 1);
        for (int i = 0; i < 9; i++) tick();
        check("ovr final index", int'(out_index), 15);
        load = 1'b1;
        tick();
        load = 1'b0;
        check("ovr acc_clr final", int'(acc_clr), 0);
        check("ovr valid drop", int'(out_valid), 0);
        tick();
        check("ovr acc_clr after", int'(acc_clr), 0);
        check("ovr still idle", int'(busy), 0);
        wait_drain("ovr");
        tick();
        check("ovr sticky", int'(overrun), 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got 1, expected 0");
        $fatal(1);
    end

endmodule
